// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command/PC geometry, opcode set, fetch record and
// fetch-stage state encoding.
package cpu_pkg;

    localparam int CMD_W     = 47;
    localparam int PC_W      = 10;
    localparam int OP_SIZE   = 5;
    localparam int ADDR_SIZE = PC_W;

    typedef enum logic [OP_SIZE-1:0] {
        NOP    = 5'd0,
        LOAD   = 5'd1,
        STORE  = 5'd2,
        ADD    = 5'd3,
        SUB    = 5'd4,
        AND_OP = 5'd5,
        OR_OP  = 5'd6,
        XOR_OP = 5'd7,
        CMP    = 5'd8,
        JMP    = 5'd9,
        JMPF   = 5'd10,
        WRTRES = 5'd11
    } opcode_e;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [CMD_W-1:0] cmd;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, command} records; flush empties it in one cycle
// and overrides any push or pop in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 57
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (level_q != LVL_W'(DEPTH)) && !flush_i;
        do_pop   = pop_i && (level_q != '0) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is datapath only; emptiness is tracked by level_q.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;

endmodule

// File: rtl/cpu_fetch_stage.sv
// Instruction-fetch front end: owns the PC, prefetches from synchronous program
// memory into fetch_fifo and hands commands to decode over valid/ready.
module cpu_fetch_stage
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_rd_en_o,
    output logic [PC_W-1:0]               imem_addr_o,
    input  logic [CMD_W-1:0]              imem_rdata_i,
    input  logic                          redirect_valid_i,
    input  logic [PC_W-1:0]               redirect_pc_i,
    output logic                          cmd_valid_o,
    input  logic                          cmd_ready_i,
    output logic [CMD_W-1:0]              cmd_data_o,
    output logic [PC_W-1:0]               cmd_pc_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  rd_pc_p1_q;
    logic             rd_vld_p1_q, rd_vld_p1_d;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] occupancy;
    logic             issue, push, pop;
    fetch_entry_t     push_entry, head_entry;

    always_comb begin
        // Reserve a slot for the read in flight so the FIFO can never overflow.
        occupancy   = level + LVL_W'(rd_vld_p1_q);
        issue       = !reset && !redirect_valid_i && (occupancy < LVL_W'(FIFO_DEPTH));
        push        = rd_vld_p1_q && !redirect_valid_i && (state_q == RUN);
        pop         = cmd_valid_o && cmd_ready_i && !redirect_valid_i;
        rd_vld_p1_d = issue;
        state_d     = redirect_valid_i ? FLUSH : RUN;
        fetch_pc_d  = fetch_pc_q;
        if (redirect_valid_i) fetch_pc_d = redirect_pc_i;
        else if (issue)       fetch_pc_d = pc_next(fetch_pc_q);
        push_entry  = '{pc: rd_pc_p1_q, cmd: imem_rdata_i};
    end

    // Issue stage: control state, killed on reset or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            fetch_pc_q  <= '0;
            rd_vld_p1_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rd_vld_p1_q <= rd_vld_p1_d;
        end
    end

    // Return stage: remembers which address the pending read belongs to.
    always_ff @(posedge clk) begin
        if (issue) rd_pc_p1_q <= fetch_pc_q;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .level_o     (level)
    );

    assign imem_rd_en_o = issue;
    assign imem_addr_o  = fetch_pc_q;
    assign cmd_valid_o  = (level != '0);
    assign cmd_data_o   = head_entry.cmd;
    assign cmd_pc_o     = head_entry.pc;
    assign fifo_level_o = level;

endmodule
